// File: rtl/ptcalc_pkg.sv
// Shared types and bus widths for the pT-calculator front end.
package ptcalc_pkg;

  // Bus payload widths; keep in step with the bus constants header.
  localparam int unsigned PL2PTCALC_LEN = 64;
  localparam int unsigned SF2PTCALC_LEN = 32;

  localparam int unsigned ST_INN = 0;
  localparam int unsigned ST_MID = 1;
  localparam int unsigned ST_OUT = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    ISSUE   = 2'd2
  } ptc_col_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset and clear.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/ptcalc_seg_collector.sv
// Gathers a pipeline candidate and up to three segments within a timed window
// and hands the assembled set to the pT core over ap_start/ap_ready.
module ptcalc_seg_collector
  import ptcalc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 32,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic [PL2PTCALC_LEN-1:0] pl_in,
  input  logic                     pl_in_vld,
  input  logic [2:0]               pl_exp_mask,
  input  logic [SF2PTCALC_LEN-1:0] sf_inn,
  input  logic [SF2PTCALC_LEN-1:0] sf_mid,
  input  logic [SF2PTCALC_LEN-1:0] sf_out,
  input  logic                     sf_inn_vld,
  input  logic                     sf_mid_vld,
  input  logic                     sf_out_vld,
  output logic                     in_ready,
  output logic [PL2PTCALC_LEN-1:0] pl2ptcalc,
  output logic [SF2PTCALC_LEN-1:0] sf2ptcalc_inn,
  output logic [SF2PTCALC_LEN-1:0] sf2ptcalc_mid,
  output logic [SF2PTCALC_LEN-1:0] sf2ptcalc_out,
  output logic                     ap_start,
  input  logic                     ap_ready,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic [CNT_W-1:0]         timeout_cnt,
  output logic [CNT_W-1:0]         orphan_cnt
);

  localparam int unsigned PL_BIT     = 3;
  localparam int unsigned TIMER_W    = 8;
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(TIMEOUT_CYC - 1);

  ptc_col_state_t            state;
  logic [3:0]                have;
  logic [2:0]                exp_mask;
  logic [TIMER_W-1:0]        timer;
  logic [PL2PTCALC_LEN-1:0]  pl_q;
  logic [SF2PTCALC_LEN-1:0]  inn_q, mid_q, out_q;

  logic [3:0]                strobe, take, have_nxt;
  logic [2:0]                mask_nxt;
  logic [PL2PTCALC_LEN-1:0]  pl_nxt;
  logic [SF2PTCALC_LEN-1:0]  inn_nxt, mid_nxt, out_nxt;
  logic [TIMER_W-1:0]        timer_dec;
  logic                      complete, dup, issue_go, orphan_go;
  logic                      drop_inc, timeout_inc;

  assign strobe    = {pl_in_vld, sf_out_vld, sf_mid_vld, sf_inn_vld};
  assign timer_dec = timer - TIMER_W'(1);

  // Merge this cycle's accepted strobes into the held candidate and decide the next move.
  always_comb begin
    take        = '0;
    dup         = 1'b0;
    have_nxt    = have;
    mask_nxt    = exp_mask;
    pl_nxt      = pl_q;
    inn_nxt     = inn_q;
    mid_nxt     = mid_q;
    out_nxt     = out_q;
    issue_go    = 1'b0;
    orphan_go   = 1'b0;
    timeout_inc = 1'b0;
    if (state != ISSUE) begin
      take     = strobe & ~have;
      dup      = |(strobe & have);
      have_nxt = have | take;
      if (take[PL_BIT]) begin
        pl_nxt   = pl_in;
        mask_nxt = pl_exp_mask;
      end
      if (take[ST_INN]) inn_nxt = sf_inn;
      if (take[ST_MID]) mid_nxt = sf_mid;
      if (take[ST_OUT]) out_nxt = sf_out;
    end
    complete = have_nxt[PL_BIT] && ((have_nxt[2:0] & mask_nxt) == mask_nxt);
    unique case (state)
      IDLE:    issue_go = (|take) && complete;
      COLLECT: begin
        if (complete) begin
          issue_go = 1'b1;
        end else if (timer_dec == '0) begin
          if (have_nxt[PL_BIT]) begin
            issue_go    = 1'b1;
            timeout_inc = 1'b1;
          end else begin
            orphan_go = 1'b1;
          end
        end
      end
      default: ;
    endcase
    drop_inc = (state == ISSUE) ? (|strobe) : dup;
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state         <= IDLE;
      have          <= '0;
      exp_mask      <= '0;
      timer         <= '0;
      pl_q          <= '0;
      inn_q         <= '0;
      mid_q         <= '0;
      out_q         <= '0;
      in_ready      <= 1'b1;
      ap_start      <= 1'b0;
      pl2ptcalc     <= '0;
      sf2ptcalc_inn <= '0;
      sf2ptcalc_mid <= '0;
      sf2ptcalc_out <= '0;
    end else begin
      have     <= have_nxt;
      exp_mask <= mask_nxt;
      pl_q     <= pl_nxt;
      inn_q    <= inn_nxt;
      mid_q    <= mid_nxt;
      out_q    <= out_nxt;
      if (issue_go) begin
        // Absent stations go out as zero, which also clears their embedded valid bit.
        state         <= ISSUE;
        timer         <= '0;
        in_ready      <= 1'b0;
        ap_start      <= 1'b1;
        pl2ptcalc     <= pl_nxt;
        sf2ptcalc_inn <= have_nxt[ST_INN] ? inn_nxt : '0;
        sf2ptcalc_mid <= have_nxt[ST_MID] ? mid_nxt : '0;
        sf2ptcalc_out <= have_nxt[ST_OUT] ? out_nxt : '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (|take) begin
              state <= COLLECT;
              timer <= TIMER_LOAD;
            end
          end
          COLLECT: begin
            if (orphan_go) begin
              state <= IDLE;
              have  <= '0;
              timer <= '0;
            end else begin
              timer <= timer_dec;
            end
          end
          ISSUE: begin
            if (ap_ready) begin
              state    <= IDLE;
              have     <= '0;
              in_ready <= 1'b1;
              ap_start <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_drop_cnt (
    .clk(ap_clk), .rst_n(ap_rst_n), .inc(drop_inc), .clr(1'b0), .cnt(drop_cnt)
  );

  sat_counter #(.W(CNT_W)) u_timeout_cnt (
    .clk(ap_clk), .rst_n(ap_rst_n), .inc(timeout_inc), .clr(1'b0), .cnt(timeout_cnt)
  );

  sat_counter #(.W(CNT_W)) u_orphan_cnt (
    .clk(ap_clk), .rst_n(ap_rst_n), .inc(orphan_go), .clr(1'b0), .cnt(orphan_cnt)
  );

endmodule
